// File: rtl/regfile_wr_arbiter.sv
// Write-port controller for the 32x32 register file: zeroes x1..x31 after reset,
// then merges the writeback stage (priority) with a buffered secondary requester.
module regfile_wr_arbiter #(
    parameter int FIFO_DEPTH     = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_write,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        sec_valid,
    input  logic [4:0]  sec_addr,
    input  logic [31:0] sec_data,
    output logic        sec_ready,
    input  logic [4:0]  rd_addr_a,
    input  logic [4:0]  rd_addr_b,
    output logic        hazard_a,
    output logic        hazard_b,
    output logic        rf_write,
    output logic [4:0]  rf_wrAddr,
    output logic [31:0] rf_wrData,
    output logic        busy,
    output logic        drop_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [4:0]         counter_r;
    logic [4:0]         counter_nxt_s;

    logic [4:0]         fifo_addr_r [FIFO_DEPTH];
    logic [31:0]        fifo_data_r [FIFO_DEPTH];
    // live_r marks an occupied entry that has not been superseded by a pipe write
    logic               live_r      [FIFO_DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;

    logic               busy_s;
    logic               pipe_issue_s;
    logic               pop_s;
    logic               enq_s;
    logic               haz_a_s;
    logic               haz_b_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Issue/handshake decode derived from registered state
    always_comb begin
        busy_s       = (state_r == ST_CLEAR);
        pipe_issue_s = !busy_s && pipe_write && (pipe_addr != 5'd0);
        pop_s        = !busy_s && !pipe_issue_s && (count_r != CNT_W'(0));
        sec_ready    = !busy_s && (count_r < CNT_W'(FIFO_DEPTH));
        enq_s        = sec_valid && sec_ready && (sec_addr != 5'd0);
        busy         = busy_s;
    end

    // Pending-write hazard lookup for the two decode source registers
    always_comb begin
        haz_a_s = 1'b0;
        haz_b_s = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            haz_a_s = haz_a_s | (live_r[i] && (fifo_addr_r[i] == rd_addr_a));
            haz_b_s = haz_b_s | (live_r[i] && (fifo_addr_r[i] == rd_addr_b));
        end
        hazard_a = haz_a_s && (rd_addr_a != 5'd0);
        hazard_b = haz_b_s && (rd_addr_b != 5'd0);
    end

    // Clear/run state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            counter_r <= 5'd1;
        end else begin
            state_r   <= state_nxt_s;
            counter_r <= counter_nxt_s;
        end
    end

    // Next-state logic: walk x1..x31 once, then run forever
    always_comb begin
        state_nxt_s   = state_r;
        counter_nxt_s = counter_r;
        case (state_r)
            ST_CLEAR: begin
                if (counter_r == 5'd31) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    counter_nxt_s = counter_r + 5'd1;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Secondary FIFO: kill older same-address entries, pop head, push tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= PTR_W'(0);
            tail_r  <= PTR_W'(0);
            count_r <= CNT_W'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_r[i] <= 5'd0;
                fifo_data_r[i] <= 32'd0;
                live_r[i]      <= 1'b0;
            end
        end else begin
            if (pipe_issue_s) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (fifo_addr_r[i] == pipe_addr) begin
                        live_r[i] <= 1'b0;
                    end
                end
            end
            if (pop_s) begin
                live_r[head_r] <= 1'b0;
                head_r         <= ptr_inc(head_r);
            end
            // the tail slot is never the head slot of a non-empty FIFO here
            if (enq_s) begin
                fifo_addr_r[tail_r] <= sec_addr;
                fifo_data_r[tail_r] <= sec_data;
                live_r[tail_r]      <= 1'b1;
                tail_r              <= ptr_inc(tail_r);
            end
            if (enq_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (!enq_s && pop_s) begin
                count_r <= count_r - CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Registered regfile write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write  <= 1'b0;
            rf_wrAddr <= 5'd0;
            rf_wrData <= 32'd0;
        end else if (busy_s) begin
            rf_write  <= 1'b1;
            rf_wrAddr <= counter_r;
            rf_wrData <= 32'd0;
        end else if (pipe_issue_s) begin
            rf_write  <= 1'b1;
            rf_wrAddr <= pipe_addr;
            rf_wrData <= pipe_data;
        end else if (pop_s) begin
            // a killed head is retired silently so the newer pipe value stands
            rf_write <= live_r[head_r];
            if (live_r[head_r]) begin
                rf_wrAddr <= fifo_addr_r[head_r];
                rf_wrData <= fifo_data_r[head_r];
            end
        end else begin
            rf_write <= 1'b0;
        end
    end

    // Sticky flag for writeback lost while clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
        end else if (pipe_write && (pipe_addr != 5'd0) && busy_s) begin
            drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus random
// traffic, checked against a queue-based reference model and a shadow regfile.
module tb_regfile_wr_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        pipe_write;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        sec_valid;
    logic [4:0]  sec_addr;
    logic [31:0] sec_data;
    logic        sec_ready;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        hazard_a;
    logic        hazard_b;
    logic        rf_write;
    logic [4:0]  rf_wrAddr;
    logic [31:0] rf_wrData;
    logic        busy;
    logic        drop_err;

    regfile_wr_arbiter #(.FIFO_DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_write(pipe_write), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .sec_valid(sec_valid), .sec_addr(sec_addr), .sec_data(sec_data),
        .sec_ready(sec_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .rf_write(rf_write), .rf_wrAddr(rf_wrAddr), .rf_wrData(rf_wrData),
        .busy(busy), .drop_err(drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        bit          live;
    } ent_t;

    int          vectors = 0;
    int          miscompares = 0;

    ent_t        fq[$];
    bit          m_busy;
    int          m_cnt;
    bit          m_wr;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_drop;
    logic [31:0] model_rf [32];

    // regfile as seen through the DUT write port, commits one edge after display
    logic [31:0] dut_rf [32];
    int          n11 = 0;
    always @(posedge clk) begin
        if (rf_write === 1'b1) begin
            dut_rf[rf_wrAddr] <= rf_wrData;
            if (rf_wrData == 32'h11) n11 <= n11 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_busy = 1'b1;
        m_cnt  = 1;
        m_wr   = 1'b0;
        m_addr = 5'd0;
        m_data = 32'd0;
        m_drop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        pipe_write = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
        sec_valid = 1'b0;  sec_addr = 5'd0;  sec_data = 32'd0;
        rd_addr_a = 5'd9;  rd_addr_b = 5'd3;
        #1;
        model_reset();
        chk("rst_rf_write", rf_write, 32'd0);
        chk("rst_rf_wrAddr", rf_wrAddr, 32'd0);
        chk("rst_rf_wrData", rf_wrData, 32'd0);
        chk("rst_busy", busy, 32'd1);
        chk("rst_sec_ready", sec_ready, 32'd0);
        chk("rst_drop_err", drop_err, 32'd0);
        chk("rst_hazard_a", hazard_a, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                        input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                        input logic [4:0] ra, input logic [4:0] rb);
        bit   er;
        bit   ha;
        bit   hb;
        ent_t e;
        @(negedge clk);
        pipe_write = pw; pipe_addr = pa; pipe_data = pd;
        sec_valid  = sv; sec_addr  = sa; sec_data  = sd;
        rd_addr_a  = ra; rd_addr_b = rb;
        #1;
        er = !m_busy && (fq.size() < DEPTH);
        ha = 1'b0;
        hb = 1'b0;
        foreach (fq[i]) begin
            if (fq[i].live && fq[i].a == ra) ha = 1'b1;
            if (fq[i].live && fq[i].a == rb) hb = 1'b1;
        end
        if (ra == 5'd0) ha = 1'b0;
        if (rb == 5'd0) hb = 1'b0;
        chk("sec_ready", sec_ready, {31'd0, er});
        chk("hazard_a", hazard_a, {31'd0, ha});
        chk("hazard_b", hazard_b, {31'd0, hb});
        chk("busy", busy, {31'd0, m_busy});

        if (pw && pa != 5'd0 && m_busy) m_drop = 1'b1;
        if (m_busy) begin
            m_wr   = 1'b1;
            m_addr = 5'(m_cnt);
            m_data = 32'd0;
            if (m_cnt == 31) m_busy = 1'b0;
            else m_cnt++;
        end else begin
            if (pw && pa != 5'd0) begin
                m_wr   = 1'b1;
                m_addr = pa;
                m_data = pd;
                foreach (fq[i]) if (fq[i].a == pa) fq[i].live = 1'b0;
            end else if (fq.size() > 0) begin
                e    = fq.pop_front();
                m_wr = e.live;
                if (e.live) begin
                    m_addr = e.a;
                    m_data = e.d;
                end
            end else begin
                m_wr = 1'b0;
            end
            if (sv && er && sa != 5'd0) begin
                e.a = sa; e.d = sd; e.live = 1'b1;
                fq.push_back(e);
            end
        end
        if (m_wr) model_rf[m_addr] = m_data;

        @(posedge clk);
        #1;
        chk("rf_write", rf_write, {31'd0, m_wr});
        chk("rf_wrAddr", rf_wrAddr, {27'd0, m_addr});
        chk("rf_wrData", rf_wrData, m_data);
        chk("drop_err", drop_err, {31'd0, m_drop});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd3);
    endtask

    task automatic cmp_regfile(input string tag);
        for (int r = 1; r < 32; r++) chk(tag, dut_rf[r], model_rf[r]);
    endtask

    initial begin
        int n11_0;
        rst_n = 1'b0;
        pipe_write = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
        sec_valid = 1'b0;  sec_addr = 5'd0;  sec_data = 32'd0;
        rd_addr_a = 5'd0;  rd_addr_b = 5'd0;
        for (int r = 0; r < 32; r++) model_rf[r] = 32'hFFFF_FFFF;

        do_reset();

        // clear sequence with a lost writeback to x5 and an ignored secondary request
        step(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6);
        step(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 32'h66, 5'd5, 5'd6);
        idle(29);
        chk("drop_err_sticky", drop_err, 32'd1);
        idle(2);
        chk("clear_x5_zero", dut_rf[5], 32'd0);
        cmp_regfile("clear_regfile");

        // priority and backpressure
        step(1'b1, 5'd7, 32'hC, 1'b1, 5'd3, 32'hA, 5'd3, 5'd4);
        step(1'b1, 5'd7, 32'hC, 1'b1, 5'd4, 32'hB, 5'd3, 5'd4);
        step(1'b1, 5'd7, 32'hC, 1'b1, 5'd5, 32'hD, 5'd3, 5'd4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hD, 5'd3, 5'd4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hD, 5'd5, 5'd4);
        idle(3);

        // kill: pipe write to x9 supersedes the queued 0x11
        n11_0 = n11;
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h11, 5'd9, 5'd0);
        step(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        idle(2);
        chk("kill_x9", dut_rf[9], 32'h22);
        chk("kill_no_0x11_write", n11 - n11_0, 32'd0);

        // same-edge pipe write and enqueue to x9: the queued one is younger
        step(1'b1, 5'd9, 32'h22, 1'b1, 5'd9, 32'h33, 5'd9, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        idle(2);
        chk("same_edge_x9", dut_rf[9], 32'h33);

        // secondary write to x0: handshake only
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77, 5'd0, 5'd0);
        idle(2);

        // random traffic concentrated on a few registers to provoke kills
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), $urandom,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        idle(DEPTH + 2);
        cmp_regfile("random_regfile");

        // reset with two entries queued, then the clear restarts at x1
        step(1'b1, 5'd2, 32'h5, 1'b1, 5'd3, 32'h6, 5'd3, 5'd4);
        step(1'b1, 5'd2, 32'h5, 1'b1, 5'd4, 32'h7, 5'd3, 5'd4);
        do_reset();
        idle(33);
        cmp_regfile("reclear_regfile");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port controller for the 32×32 register file. It zeroes x1–x31 after reset, then shares the regfile's single write port between two sources. The pipeline writeback stage has absolute priority. A secondary requester (load/multi-cycle unit, debug) is buffered in a small in-order FIFO. The block sits between writeback and the regfile `write`/`wrAddr`/`wrData` inputs, and reports pending-write hazards to decode.

## Interface
- `FIFO_DEPTH`, 2: secondary-request buffer entries; legal range 2–8.
- `CLEAR_ON_RESET`, 1: 1 runs the 31-cycle zeroing sequence after reset; 0 enters RUN directly.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pipe_write`  in  1  writeback write enable.
- `pipe_addr`  in  5  writeback destination register.
- `pipe_data`  in  32  writeback data.
- `sec_valid`  in  1  secondary request valid.
- `sec_addr`  in  5  secondary destination register.
- `sec_data`  in  32  secondary data.
- `sec_ready`  out  1  secondary request accepted this cycle when high with `sec_valid`.
- `rd_addr_a`, `rd_addr_b`  in  5 each  decode source registers.
- `hazard_a`, `hazard_b`  out  1 each  source has a pending, un-issued FIFO write.
- `rf_write`  out  1  to regfile `write`.
- `rf_wrAddr`  out  5  to regfile `wrAddr`.
- `rf_wrData`  out  32  to regfile `wrData`.
- `busy`  out  1  clear sequence in progress; the core must hold writeback.
- `drop_err`  out  1  sticky; a pipeline write was lost during `busy`.

## Operation
- Reset values: `rf_write`=0, `rf_wrAddr`=0, `rf_wrData`=0, `drop_err`=0, FIFO empty.
- Reset state: CLEAR with counter=1 if `CLEAR_ON_RESET`, else RUN.
- `busy` = (state==CLEAR), so it is 1 from reset when clearing is enabled. `sec_ready` = !busy && count<FIFO_DEPTH, so it is 0 during reset.
- CLEAR, per edge: `rf_*` <= {1, counter, 0}.
  - If counter==31, go to RUN; otherwise counter++.
  - All inputs are ignored except `drop_err` detection.
- `drop_err` is set when `pipe_write`=1, `pipe_addr`≠0 and `busy`=1. It is cleared only by `rst_n`.
- RUN, per edge, in priority order:
  1. `pipe_write` and `pipe_addr`≠0: `rf_*` <= pipe fields.
  2. Otherwise, FIFO non-empty: `rf_*` <= head entry, and the head is popped.
  3. Otherwise: `rf_write` <= 0; `rf_wrAddr`/`rf_wrData` hold their values.
- Writes to x0 from either source are never issued.
  - A pipeline write to x0 does not block the FIFO.
  - A secondary write to x0 completes its handshake but is not enqueued.
- Enqueue on `sec_valid && sec_ready`. Enqueue and pop in the same edge are both legal.
- Ordering kill: an issued pipeline write to X invalidates every valid FIFO entry with addr X that was already present before this edge.
  - Killed entries are later popped without issuing a write (no `rf_write` that cycle), which keeps the newer pipeline value.
  - An entry for X enqueued in the same edge is the younger write; it survives and issues later.
- Hazard outputs are combinational: `hazard_a` = OR over valid, un-killed entries of (addr==`rd_addr_a`), forced 0 when `rd_addr_a`==0. `hazard_b` is defined the same way.
- Asserting `rst_n` mid-operation discards the FIFO, aborts any issue, and restarts CLEAR from counter=1.

## Timing
- Pipeline write: presented in cycle N, appears on `rf_*` after edge N; the regfile commits at edge N+1.
- Secondary write: accepted at edge N; earliest appearance on `rf_*` is after edge N+1, and only if no pipeline write is issued in cycle N+1.
  - The pipeline can delay it indefinitely; the FIFO preserves order.
- Clear sequence: 31 edges. After edge k (k=1..31), `rf_wrAddr`=k. `busy` falls after edge 31.
- FIFO full: `sec_ready`=0 from the edge that fills it until the edge that pops an entry.
- `hazard_*` clears in the cycle after the matching entry issues or is killed.

## Test plan
- Clear sequence: release `rst_n` → `rf_write`=1 for 31 consecutive cycles with `rf_wrAddr`=1..31 and `rf_wrData`=0; then `busy`=0 and `sec_ready`=1.
- Busy drop: `pipe_write`=1, `pipe_addr`=5 during CLEAR → `drop_err`=1 and stays 1; no write of x5 with that data occurs.
- Priority and backpressure: with `FIFO_DEPTH`=2, enqueue x3=0xA and x4=0xB, then a third request while the pipe writes x7=0xC for 3 cycles →
  - `sec_ready`=0 while the FIFO is full;
  - `rf_*` shows x7=0xC for 3 cycles, then x3=0xA, then x4=0xB.
- Kill: FIFO holds x9=0x11, then pipe writes x9=0x22 → `hazard_a` (`rd_addr_a`=9) drops next cycle; the regfile ends with x9=0x22 and no 0x11 write is issued.
- Same-cycle order: the pipe writes x9=0x22 in the same edge that x9=0x33 is enqueued → 0x22 issues first, then 0x33.
- x0 and reset: secondary write to x0 → handshake completes, no `rf_write`. `rst_n` low while the FIFO holds 2 entries → FIFO empties, `rf_write`=0, CLEAR restarts at x1.
